// File: rtl/trace_defs.sv
// Shared definitions for the serial trace transmitter: frame constants,
// the transmit state encoding and the byte selector used to walk a record.
package trace_defs;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         FRAME_BYTES = 10;
   localparam int         REC_W       = 72;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_t;

   // Picks the byte that goes on the wire at position idx of a frame.
   // Position 0 is the sync marker; positions 1..9 walk the record
   // {C, I, count} from its least significant byte upward, which yields
   // count first, then I and C each little-endian.
   function automatic logic [7:0] frameByte(input logic [REC_W-1:0] rec,
                                            input logic [3:0]       idx);
      logic [7:0] sel;
      case (idx)
         4'd1:    sel = rec[7:0];
         4'd2:    sel = rec[15:8];
         4'd3:    sel = rec[23:16];
         4'd4:    sel = rec[31:24];
         4'd5:    sel = rec[39:32];
         4'd6:    sel = rec[47:40];
         4'd7:    sel = rec[55:48];
         4'd8:    sel = rec[63:56];
         4'd9:    sel = rec[71:64];
         default: sel = SYNC_BYTE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Two-entry record buffer. Slot 0 is always the oldest record, so the
// head is a plain wire and a pop simply shifts slot 1 down. The caller
// guarantees it never pushes into a full buffer without popping and
// never pops an empty one.
module trace_fifo
   import trace_defs::*;
(
   input  logic             clk1,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [REC_W-1:0] din,
   output logic [REC_W-1:0] head,
   output logic [1:0]       level
);

   logic [REC_W-1:0] slot0;
   logic [REC_W-1:0] slot1;

   // Storage and occupancy. A simultaneous push and pop keeps the level
   // constant: with one entry the new record replaces the head directly,
   // with two entries slot 1 moves to the head and the new record lands
   // behind it.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         slot0 <= '0;
         slot1 <= '0;
         level <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (level == 2'd0) begin
                  slot0 <= din;
               end else begin
                  slot1 <= din;
               end
               level <= level + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               level <= level - 2'd1;
            end
            2'b11: begin
               if (level == 2'd1) begin
                  slot0 <= din;
               end else begin
                  slot0 <= slot1;
                  slot1 <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head = slot0;

endmodule

// File: rtl/trace_uart_tx.sv
// Debug-side trace transmitter. Each captured {C, I, count} record is
// buffered and later sent as a 10-byte 8N1 UART frame led by a sync byte.
// Captures that find the buffer full are dropped and flagged sticky.
module trace_uart_tx
   import trace_defs::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic        clk1,
   input  logic        reset,
   input  logic        capture,
   input  logic [7:0]  count,
   input  logic [31:0] I,
   input  logic [31:0] C,
   output logic        tx,
   output logic        busy,
   output logic [1:0]  level,
   output logic        overflow
);

   localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        LAST_BYTE = 4'(FRAME_BYTES - 1);

   txState_t          state;
   txState_t          stateNext;
   logic [BAUD_W-1:0] baudCnt;
   logic [BAUD_W-1:0] baudNext;
   logic [2:0]        bitIdx;
   logic [2:0]        bitNext;
   logic [3:0]        byteIdx;
   logic [3:0]        byteNext;
   logic [REC_W-1:0]  curRec;
   logic [REC_W-1:0]  fifoHead;
   logic [7:0]        curByte;
   logic              pop;
   logic              push;
   logic              txNext;
   logic              busyNext;
   logic [1:0]        levelNext;

   trace_fifo fifo (
      .clk1  (clk1),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({C, I, count}),
      .head  (fifoHead),
      .level (level)
   );

   // Transmit sequencing. The baud counter paces every bit; DATA walks
   // eight bits, STOP either moves to the next byte of the frame or, at
   // the end of the frame, chains straight into the next buffered record
   // so frames go out back-to-back. Popping happens on the same edge the
   // START bit begins, which is also when the record is latched.
   always_comb begin
      stateNext = state;
      baudNext  = baudCnt;
      bitNext   = bitIdx;
      byteNext  = byteIdx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (level != 2'd0) begin
               pop       = 1'b1;
               stateNext = START;
               baudNext  = '0;
               bitNext   = 3'd0;
               byteNext  = 4'd0;
            end
         end
         START: begin
            if (baudCnt == BAUD_LAST) begin
               baudNext  = '0;
               bitNext   = 3'd0;
               stateNext = DATA;
            end else begin
               baudNext = baudCnt + 1'b1;
            end
         end
         DATA: begin
            if (baudCnt == BAUD_LAST) begin
               baudNext = '0;
               if (bitIdx == 3'd7) begin
                  bitNext   = 3'd0;
                  stateNext = STOP;
               end else begin
                  bitNext = bitIdx + 3'd1;
               end
            end else begin
               baudNext = baudCnt + 1'b1;
            end
         end
         STOP: begin
            if (baudCnt == BAUD_LAST) begin
               baudNext = '0;
               if (byteIdx != LAST_BYTE) begin
                  byteNext  = byteIdx + 4'd1;
                  stateNext = START;
               end else begin
                  byteNext = 4'd0;
                  if (level != 2'd0) begin
                     pop       = 1'b1;
                     stateNext = START;
                  end else begin
                     stateNext = IDLE;
                  end
               end
            end else begin
               baudNext = baudCnt + 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Buffer admission and the registered output values. A capture is
   // accepted whenever there is room, including the full case where a pop
   // frees a slot on the same edge. The line level is computed from the
   // next state so that tx itself is a flop with no decode glitches.
   always_comb begin
      push      = capture && ((level != 2'd2) || pop);
      levelNext = level + {1'b0, push} - {1'b0, pop};
      busyNext  = (stateNext != IDLE) || (levelNext != 2'd0);
      curByte   = frameByte(curRec, byteNext);
      case (stateNext)
         START:   txNext = 1'b0;
         DATA:    txNext = curByte[bitNext];
         default: txNext = 1'b1;
      endcase
   end

   // State, counters, the record being sent, and the registered outputs.
   // Reset abandons any frame in flight and returns the line to idle high.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= 3'd0;
         byteIdx  <= 4'd0;
         curRec   <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state   <= stateNext;
         baudCnt <= baudNext;
         bitIdx  <= bitNext;
         byteIdx <= byteNext;
         if (pop) begin
            curRec <= fifoHead;
         end
         tx   <= txNext;
         busy <= busyNext;
         if (capture && !push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for the trace transmitter: one instance at four clocks
// per bit and one at a single clock per bit, with frames decoded from the
// line and compared against hand-built byte sequences.
module tb_trace_uart_tx;

   logic        clk1 = 1'b0;
   logic        reset;
   logic        capture4, capture1;
   logic [7:0]  count4, count1;
   logic [31:0] i4, c4, i1, c1;
   logic        tx4, busy4, overflow4;
   logic        tx1, busy1, overflow1;
   logic [1:0]  level4, level1;
   logic        useFast = 1'b0;
   wire         rxLine = useFast ? tx1 : tx4;

   int assertCount = 0;
   int failCount   = 0;

   trace_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk1     (clk1),
      .reset    (reset),
      .capture  (capture4),
      .count    (count4),
      .I        (i4),
      .C        (c4),
      .tx       (tx4),
      .busy     (busy4),
      .level    (level4),
      .overflow (overflow4)
   );

   trace_uart_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk1     (clk1),
      .reset    (reset),
      .capture  (capture1),
      .count    (count1),
      .I        (i1),
      .C        (c1),
      .tx       (tx1),
      .busy     (busy1),
      .level    (level1),
      .overflow (overflow1)
   );

   // Free-running clock, period 10.
   always #5 clk1 = ~clk1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit fast, input logic cap, input logic [7:0] cnt,
                                input logic [31:0] ins, input logic [31:0] alu);
      if (fast) begin
         capture1 = cap; count1 = cnt; i1 = ins; c1 = alu;
      end else begin
         capture4 = cap; count4 = cnt; i4 = ins; c4 = alu;
      end
   endtask

   // Waits (bounded) for a start bit, then samples a whole frame near the
   // middle of each bit and checks every byte and the framing bits.
   // Returns at the negedge of the last bit period of the frame.
   task automatic recvFrame(input bit fast, input int cpb, input int expWait,
                            input logic [7:0] cnt, input logic [31:0] ins,
                            input logic [31:0] alu, input string tag);
      logic [99:0] frameBits;
      logic [7:0]  expBytes [10];
      logic [7:0]  gotByte;
      int          waited;
      int          framingErrs;
      bit          found;
      useFast     = fast;
      expBytes[0] = 8'hA5;
      expBytes[1] = cnt;
      for (int k = 0; k < 4; k++) begin
         expBytes[2+k] = ins[8*k +: 8];
         expBytes[6+k] = alu[8*k +: 8];
      end
      frameBits = '1;
      waited    = 0;
      found     = 1'b0;
      while (!found && waited < 2000) begin
         @(negedge clk1);
         waited++;
         if (rxLine === 1'b0) found = 1'b1;
      end
      checkOutput({tag, " start delay"}, 32'(waited), 32'(expWait));
      if (found) begin
         for (int n = 0; n < 100 * cpb; n++) begin
            if (n > 0) @(negedge clk1);
            if ((n % cpb) == (cpb / 2)) frameBits[n / cpb] = rxLine;
         end
         framingErrs = 0;
         for (int b = 0; b < 10; b++) begin
            if (frameBits[b*10] !== 1'b0) framingErrs++;
            if (frameBits[b*10+9] !== 1'b1) framingErrs++;
            gotByte = frameBits[b*10+1 +: 8];
            checkOutput($sformatf("%s byte%0d", tag, b), 32'(gotByte), 32'(expBytes[b]));
         end
         checkOutput({tag, " framing"}, 32'(framingErrs), 32'd0);
      end
   endtask

   // Single capture on the slow instance followed by the full frame and
   // the busy fall exactly one edge after the final stop bit.
   task automatic singleFrame(input logic [7:0] cnt, input logic [31:0] ins,
                              input logic [31:0] alu, input string tag);
      applyStimulus(1'b0, 1'b1, cnt, ins, alu);
      fork
         begin
            @(negedge clk1);
            checkOutput({tag, " level after capture"}, 32'(level4), 32'd1);
            checkOutput({tag, " busy after capture"}, 32'(busy4), 32'd1);
            applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
         end
         recvFrame(1'b0, 4, 2, cnt, ins, alu, tag);
      join
      checkOutput({tag, " busy last bit"}, 32'(busy4), 32'd1);
      @(negedge clk1);
      checkOutput({tag, " busy after frame"}, 32'(busy4), 32'd0);
      checkOutput({tag, " tx after frame"}, 32'(tx4), 32'd1);
      checkOutput({tag, " level after frame"}, 32'(level4), 32'd0);
   endtask

   initial begin
      bit stable;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);

      // Reset state, then 50 idle cycles with nothing moving.
      repeat (3) @(negedge clk1);
      checkOutput("reset tx", 32'(tx4), 32'd1);
      checkOutput("reset busy", 32'(busy4), 32'd0);
      checkOutput("reset level", 32'(level4), 32'd0);
      checkOutput("reset overflow", 32'(overflow4), 32'd0);
      checkOutput("reset fast tx", 32'(tx1), 32'd1);
      reset  = 1'b0;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk1);
         if (tx4 !== 1'b1 || busy4 !== 1'b0 || level4 !== 2'd0 || overflow4 !== 1'b0 ||
             tx1 !== 1'b1 || busy1 !== 1'b0) stable = 1'b0;
      end
      checkOutput("idle stable", 32'(stable), 32'd1);
      $display("[TB] idle check done");

      // Single record.
      singleFrame(8'h04, 32'h00500093, 32'h00000005, "single");

      // Four captures on consecutive edges: three sent, the fourth dropped.
      applyStimulus(1'b0, 1'b1, 8'h10, 32'h11223344, 32'h55667788);
      fork
         begin
            @(negedge clk1);
            checkOutput("burst level E1", 32'(level4), 32'd1);
            applyStimulus(1'b0, 1'b1, 8'h20, 32'hA1B2C3D4, 32'h0BADF00D);
            @(negedge clk1);
            checkOutput("burst level E2", 32'(level4), 32'd1);
            applyStimulus(1'b0, 1'b1, 8'h30, 32'hDEADBEEF, 32'h12345678);
            @(negedge clk1);
            checkOutput("burst level E3", 32'(level4), 32'd2);
            checkOutput("burst overflow E3", 32'(overflow4), 32'd0);
            applyStimulus(1'b0, 1'b1, 8'h40, 32'hCAFEBABE, 32'h87654321);
            @(negedge clk1);
            checkOutput("burst level E4", 32'(level4), 32'd2);
            checkOutput("burst overflow E4", 32'(overflow4), 32'd1);
            applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
         end
         recvFrame(1'b0, 4, 2, 8'h10, 32'h11223344, 32'h55667788, "burst R1");
      join
      recvFrame(1'b0, 4, 1, 8'h20, 32'hA1B2C3D4, 32'h0BADF00D, "burst R2");
      recvFrame(1'b0, 4, 1, 8'h30, 32'hDEADBEEF, 32'h12345678, "burst R3");
      checkOutput("burst busy last bit", 32'(busy4), 32'd1);
      @(negedge clk1);
      checkOutput("burst busy after", 32'(busy4), 32'd0);
      checkOutput("burst level after", 32'(level4), 32'd0);
      checkOutput("burst overflow sticky", 32'(overflow4), 32'd1);
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk1);
         if (tx4 !== 1'b1) stable = 1'b0;
      end
      checkOutput("burst R4 not sent", 32'(stable), 32'd1);

      reset = 1'b1;
      @(negedge clk1);
      reset = 1'b0;
      checkOutput("overflow cleared by reset", 32'(overflow4), 32'd0);
      @(negedge clk1);

      // Capture on the edge that ends R5's last stop bit while full.
      applyStimulus(1'b0, 1'b1, 8'h51, 32'h01020304, 32'hF0E0D0C0);
      fork
         begin
            @(negedge clk1);
            checkOutput("edge level E1", 32'(level4), 32'd1);
            applyStimulus(1'b0, 1'b1, 8'h62, 32'h89ABCDEF, 32'h00FF00FF);
            @(negedge clk1);
            applyStimulus(1'b0, 1'b1, 8'h73, 32'h76543210, 32'hA5A55A5A);
            @(negedge clk1);
            applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
            checkOutput("edge level queued", 32'(level4), 32'd2);
            repeat (398) @(negedge clk1);
            checkOutput("edge level before", 32'(level4), 32'd2);
            applyStimulus(1'b0, 1'b1, 8'h84, 32'hFEDCBA98, 32'h13579BDF);
            @(negedge clk1);
            applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
            checkOutput("edge level after", 32'(level4), 32'd2);
            checkOutput("edge overflow", 32'(overflow4), 32'd0);
         end
         recvFrame(1'b0, 4, 2, 8'h51, 32'h01020304, 32'hF0E0D0C0, "edge R5");
      join
      recvFrame(1'b0, 4, 1, 8'h62, 32'h89ABCDEF, 32'h00FF00FF, "edge R6");
      recvFrame(1'b0, 4, 1, 8'h73, 32'h76543210, 32'hA5A55A5A, "edge R7");
      recvFrame(1'b0, 4, 1, 8'h84, 32'hFEDCBA98, 32'h13579BDF, "edge R8");
      @(negedge clk1);
      checkOutput("edge busy after", 32'(busy4), 32'd0);
      checkOutput("edge overflow final", 32'(overflow4), 32'd0);

      // Reset while a data bit of byte 3 holds the line low.
      applyStimulus(1'b0, 1'b1, 8'h99, 32'h13570F24, 32'h2468ACE0);
      @(negedge clk1);
      applyStimulus(1'b0, 1'b1, 8'hAA, 32'h11111111, 32'h22222222);
      @(negedge clk1);
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
      checkOutput("midreset start bit", 32'(tx4), 32'd0);
      checkOutput("midreset level before", 32'(level4), 32'd1);
      repeat (140) @(negedge clk1);
      checkOutput("midreset line low before", 32'(tx4), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("midreset tx async", 32'(tx4), 32'd1);
      checkOutput("midreset level", 32'(level4), 32'd0);
      checkOutput("midreset busy", 32'(busy4), 32'd0);
      @(negedge clk1);
      reset = 1'b0;
      @(negedge clk1);
      singleFrame(8'h3C, 32'hC001D00D, 32'h0000FFFF, "after reset");

      // One clock per bit: two frames, the second starting right after the first.
      applyStimulus(1'b1, 1'b1, 8'h01, 32'h40000513, 32'h7FFFFFFF);
      fork
         begin
            @(negedge clk1);
            applyStimulus(1'b1, 1'b1, 8'h02, 32'h00A50533, 32'h80000000);
            @(negedge clk1);
            applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);
            checkOutput("fast level", 32'(level1), 32'd1);
         end
         recvFrame(1'b1, 1, 2, 8'h01, 32'h40000513, 32'h7FFFFFFF, "fast R1");
      join
      recvFrame(1'b1, 1, 1, 8'h02, 32'h00A50533, 32'h80000000, "fast R2");
      checkOutput("fast busy last bit", 32'(busy1), 32'd1);
      @(negedge clk1);
      checkOutput("fast busy after", 32'(busy1), 32'd0);
      checkOutput("fast tx after", 32'(tx1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
